// File: rtl/ir_scan_scheduler.sv
// ============================================================================
// Module   : ir_scan_scheduler
// Brief    : Round-robin IR reflectance scan with per-sensor majority flag,
//            white-to-black crossing counters and a req/ack count clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ir_scan_scheduler #(
    parameter int NUM_SENS   = 4,
    parameter int SETTLE     = 100,
    parameter int SAMPLE_LEN = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  inSignal,
    output logic [NUM_SENS-1:0]   emit_en,
    output logic [NUM_SENS-1:0]   black,
    output logic [8*NUM_SENS-1:0] conteo,
    output logic                  scan_done,
    input  logic                  clr_req,
    output logic                  clr_ack
);

    localparam int TMAX = (SETTLE > SAMPLE_LEN) ? SETTLE : SAMPLE_LEN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(NUM_SENS);
    localparam int HW   = $clog2(SAMPLE_LEN + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_LEN - 1);
    localparam logic [HW-1:0] HALF        = HW'(SAMPLE_LEN / 2);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_SENS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [HW-1:0]        hits_q,  hits_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [NUM_SENS-1:0]  black_q, black_d;
    logic [7:0]           cnt_q [NUM_SENS];
    logic [7:0]           cnt_d [NUM_SENS];
    logic                 ack_q,   ack_d;
    logic                 new_black;
    logic                 clearing;

    assign new_black = (hits_q > HALF);
    assign clearing  = clr_req && !ack_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            hits_q  <= '0;
            idx_q   <= '0;
            black_q <= '0;
            ack_q   <= 1'b0;
            for (int i = 0; i < NUM_SENS; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hits_q  <= hits_d;
            idx_q   <= idx_d;
            black_q <= black_d;
            ack_q   <= ack_d;
            for (int i = 0; i < NUM_SENS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hits_d    = hits_q;
        idx_d     = idx_q;
        black_d   = black_q;
        emit_en   = '0;
        scan_done = 1'b0;
        for (int i = 0; i < NUM_SENS; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (run) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                emit_en[idx_q] = 1'b1;
                if (timer_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    timer_d = '0;
                    hits_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SAMPLE: begin
                emit_en[idx_q] = 1'b1;
                hits_d = hits_q + HW'(inSignal);
                if (timer_q == SAMPLE_LAST) begin
                    state_d = S_UPDATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_UPDATE: begin
                black_d[idx_q] = new_black;
                // Only a white-to-black transition counts as a crossing.
                if (!black_q[idx_q] && new_black) begin
                    cnt_d[idx_q] = cnt_q[idx_q] + 8'd1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    scan_done = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                state_d = run ? S_SETTLE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A clear overrides any increment landing on the same edge.
        if (clearing) begin
            for (int i = 0; i < NUM_SENS; i++) begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    always_comb begin
        ack_d = ack_q;
        if (clearing) begin
            ack_d = 1'b1;
        end else if (!clr_req) begin
            ack_d = 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < NUM_SENS; g++) begin : g_pack
            assign conteo[8*g +: 8] = cnt_q[g];
        end
    endgenerate

    assign black   = black_q;
    assign clr_ack = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_scan_scheduler.sv
// ============================================================================
// Module   : tb_ir_scan_scheduler
// Brief    : Randomized bench for ir_scan_scheduler against a slot-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ir_scan_scheduler;

    localparam int N  = 4;
    localparam int ST = 4;
    localparam int SL = 8;
    localparam int L  = ST + SL + 1;

    logic           clock    = 1'b0;
    logic           reset    = 1'b0;
    logic           run      = 1'b0;
    logic           inSignal = 1'b0;
    logic           clr_req  = 1'b0;
    logic [N-1:0]   emit_en;
    logic [N-1:0]   black;
    logic [8*N-1:0] conteo;
    logic           scan_done;
    logic           clr_ack;

    ir_scan_scheduler #(
        .NUM_SENS   (N),
        .SETTLE     (ST),
        .SAMPLE_LEN (SL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .inSignal  (inSignal),
        .emit_en   (emit_en),
        .black     (black),
        .conteo    (conteo),
        .scan_done (scan_done),
        .clr_req   (clr_req),
        .clr_ack   (clr_ack)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each sensor occupies a slot of L cycles; pos is the offset in it.
    bit m_active;
    int m_pos;
    int m_idx;
    int m_hits;
    bit m_black [N];
    int m_cnt   [N];
    bit m_ack;
    int k_target;
    bit par;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_idx    = 0;
        m_hits   = 0;
        m_ack    = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_black[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_edge();
        bit clearing;
        bit nb;
        clearing = clr_req && !m_ack;
        if (!m_active) begin
            if (run) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (m_pos == L - 1) begin
            nb = (m_hits > SL / 2);
            if (!m_black[m_idx] && nb) m_cnt[m_idx] = (m_cnt[m_idx] + 1) % 256;
            m_black[m_idx] = nb;
            m_idx    = (m_idx + 1) % N;
            m_pos    = 0;
            m_active = run;
        end else begin
            if (m_pos == ST) m_hits = int'(inSignal);
            else if (m_pos > ST) m_hits += int'(inSignal);
            m_pos++;
        end
        if (clearing) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ack = 1'b1;
        end else if (!clr_req) begin
            m_ack = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [N-1:0]   e_emit;
        logic [N-1:0]   e_black;
        logic [8*N-1:0] e_cnt;
        logic           e_done;
        e_emit = '0;
        if (m_active && m_pos < ST + SL) e_emit[m_idx] = 1'b1;
        e_done = m_active && (m_pos == L - 1) && (m_idx == N - 1);
        for (int i = 0; i < N; i++) begin
            e_black[i]     = m_black[i];
            e_cnt[8*i +: 8] = 8'(m_cnt[i]);
        end
        chk_eq("emit_en",   64'(emit_en),   64'(e_emit));
        chk_eq("black",     64'(black),     64'(e_black));
        chk_eq("conteo",    64'(conteo),    64'(e_cnt));
        chk_eq("scan_done", 64'(scan_done), 64'(e_done));
        chk_eq("clr_ack",   64'(clr_ack),   64'(m_ack));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // mode 0: random k per slot; mode 1: sensor 2 alternates white/black.
    task automatic drive_in(input int mode);
        if (m_active && m_pos == 0) begin
            if (mode == 1 && m_idx == 2) begin
                par      = ~par;
                k_target = par ? SL : 0;
            end else begin
                k_target = $urandom_range(0, SL);
            end
        end
        if (m_active && m_pos >= ST && m_pos < ST + SL)
            inSignal = ((m_pos - ST) < k_target);
        else
            inSignal = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int  found;
        model_reset();
        k_target = 0;
        par      = 1'b0;

        #12;
        chk_eq("rst_emit",  64'(emit_en),   64'd0);
        chk_eq("rst_black", 64'(black),     64'd0);
        chk_eq("rst_cnt",   64'(conteo),    64'd0);
        chk_eq("rst_done",  64'(scan_done), 64'd0);
        chk_eq("rst_ack",   64'(clr_ack),   64'd0);
        reset = 1'b1;
        run   = 1'b1;
        drive_in(0);
        cycle();
        chk_eq("first_emit", 64'(emit_en), 64'd1);

        // Asynchronous reset in the middle of a sample window.
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (m_active && m_pos == ST + 3) found = 1;
            else begin
                drive_in(0);
                cycle();
            end
        end
        chk_eq("reach_sample", 64'(found), 64'd1);
        #3 reset = 1'b0;
        #1;
        chk_eq("arst_emit",  64'(emit_en),   64'd0);
        chk_eq("arst_black", 64'(black),     64'd0);
        chk_eq("arst_cnt",   64'(conteo),    64'd0);
        chk_eq("arst_done",  64'(scan_done), 64'd0);
        chk_eq("arst_ack",   64'(clr_ack),   64'd0);
        model_reset();
        @(posedge clock);
        #1;
        check_all();
        #2 reset = 1'b1;
        drive_in(0);
        cycle();
        chk_eq("resume_emit", 64'(emit_en), 64'd1);

        // Randomized run, input density and clear handshakes.
        for (int c = 0; c < 4000; c++) begin
            drive_in(0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if (!clr_req) clr_req = ($urandom_range(0, 49) == 0);
            else if (m_ack) clr_req = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Long continuous scan so sensor 2's counter wraps past 255.
        run     = 1'b1;
        clr_req = 1'b0;
        for (int c = 0; c < 1030 * N * L; c++) begin
            drive_in(1);
            cycle();
        end

        // Clear requested exactly on an incrementing update edge.
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            drive_in(0);
            if (m_active && m_pos == L - 1 && !m_black[m_idx] && m_hits > SL / 2 && !m_ack) begin
                found   = 1;
                clr_req = 1'b1;
                k_target = m_idx;
            end
            cycle();
        end
        chk_eq("clr_upd_found", 64'(found), 64'd1);
        chk_eq("clr_upd_cnt", 64'(conteo[8*k_target +: 8]), 64'd0);
        chk_eq("clr_upd_ack", 64'(clr_ack), 64'd1);
        for (int c = 0; c < 10; c++) begin
            drive_in(0);
            cycle();
        end
        clr_req = 1'b0;
        drive_in(0);
        cycle();
        chk_eq("clr_drop_ack", 64'(clr_ack), 64'd0);

        // Drop run mid-slot, let the sensor finish, then resume.
        run = 1'b0;
        for (int c = 0; c < 3 * L; c++) begin
            drive_in(0);
            cycle();
        end
        chk_eq("idle_emit", 64'(emit_en), 64'd0);
        run = 1'b1;
        for (int c = 0; c < 200; c++) begin
            drive_in(0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
